// File: rtl/pipe_pkg.sv
// pipe_pkg: shared opcodes, NOP word and stage record for the hazard controller
package pipe_pkg;
  localparam logic [31:0] NOP     = 32'hD503201F;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [4:0]  XZR     = 5'd31;
  typedef struct packed {
    logic [31:0] instr;
    logic        rw;
  } stage_t;
  function automatic logic uses_rt(input logic [31:0] i);
    return (i[31:21] == OP_STUR) || (i[31:24] == OP_CBZ);
  endfunction
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: one pipeline stage register (instruction + RegWrite) with hold and NOP load
module pipe_reg
  import pipe_pkg::*;
(
  input  logic   clk,
  input  logic   en_i,
  input  logic   nop_i,
  input  stage_t d_i,
  output stage_t q_o
);
  stage_t q_q;
  // loading a bubble wins over holding, so reset/flush always clear the stage
  always_ff @(posedge clk)
    if (nop_i) q_q <= '{instr: NOP, rw: 1'b0};
    else if (en_i) q_q <= d_i;
  assign q_o = q_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RF/EX/MEM/WB instruction pipeline with load-use stall and flush
module pipe_hazard_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_if,
  input  logic        RegWrite_dec,
  input  logic        flush,
  output logic [31:0] instr_reg,
  output logic [31:0] instr_reg_ex,
  output logic [31:0] instr_reg_mem,
  output logic [31:0] instr_reg_wb,
  output logic        RegWrite_exe,
  output logic        RegWrite_reg_mem,
  output logic        RegWrite_wb,
  output logic        stall,
  output logic [15:0] stall_count
);
  stage_t      rf_q, ex_q, mem_q, wb_q;
  logic        hazard, unused_rf_rw;
  logic [4:0]  rd_ex;
  logic [15:0] stall_count_q;
  assign rd_ex = ex_q.instr[4:0];
  // load in EX writing a real register that the RF instruction reads (Rt only for STUR/CBZ)
  always_comb begin
    hazard = (ex_q.instr[31:21] == OP_LDUR) && ex_q.rw && (rd_ex != XZR) ?
             (rd_ex == rf_q.instr[9:5]) || (rd_ex == rf_q.instr[20:16]) ||
             (uses_rt(rf_q.instr) && rd_ex == rf_q.instr[4:0]) : 1'b0;
  end
  assign stall = hazard & ~flush;
  pipe_reg u_rf (
    .clk  (clk),
    .en_i (~stall),
    .nop_i(reset | flush),
    .d_i  (stage_t'({instr_if, 1'b0})),
    .q_o  (rf_q)
  );
  pipe_reg u_ex (
    .clk  (clk),
    .en_i (1'b1),
    .nop_i(reset | flush | stall),
    .d_i  (stage_t'({rf_q.instr, RegWrite_dec})),
    .q_o  (ex_q)
  );
  pipe_reg u_mem (
    .clk  (clk),
    .en_i (1'b1),
    .nop_i(reset),
    .d_i  (ex_q),
    .q_o  (mem_q)
  );
  pipe_reg u_wb (
    .clk  (clk),
    .en_i (1'b1),
    .nop_i(reset),
    .d_i  (mem_q),
    .q_o  (wb_q)
  );
  // saturating count of cycles spent stalled
  always_ff @(posedge clk)
    if (reset) stall_count_q <= '0;
    else if (stall && stall_count_q != 16'hFFFF) stall_count_q <= stall_count_q + 16'd1;
  assign unused_rf_rw     = rf_q.rw;
  assign instr_reg        = rf_q.instr;
  assign instr_reg_ex     = ex_q.instr;
  assign instr_reg_mem    = mem_q.instr;
  assign instr_reg_wb     = wb_q.instr;
  assign RegWrite_exe     = ex_q.rw;
  assign RegWrite_reg_mem = mem_q.rw;
  assign RegWrite_wb      = wb_q.rw;
  assign stall_count      = stall_count_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: instr_if  input  32  instruction word fetched this cycle.
REQ-004 SHALL have ports: RegWrite_dec  input  1  RegWrite decoded combinationally from current instr_reg.
REQ-005 SHALL have ports: flush  input  1  taken-branch redirect, kills wrong-path RF/EX contents.
REQ-006 SHALL have ports: instr_reg, instr_reg_ex, instr_reg_mem, instr_reg_wb  output  32 each  instruction held in RF/EX/MEM/WB stages.
REQ-007 SHALL have ports: RegWrite_exe, RegWrite_reg_mem, RegWrite_wb  output  1 each  RegWrite travelling with EX/MEM/WB instruction.
REQ-008 SHALL have ports: stall  output  1  combinational load-use stall, holds PC and instr_reg.
REQ-009 SHALL have ports: stall_count  output  16  saturating count of stall cycles.
REQ-010 SHALL use one clock; reset is synchronous and active-high, ports named clk and reset.

Function
REQ-011 SHALL define NOP = 32'hD503201F; bubbles carry NOP with RegWrite 0.
REQ-012 SHALL assert stall when all hold: instr_reg_ex[31:21]==11'b11111000010 (LDUR); RegWrite_exe==1; instr_reg_ex[4:0]!=31; and rd_ex equals instr_reg[9:5] or instr_reg[20:16], or equals instr_reg[4:0] when instr_reg is STUR (11'b11111000000) or CBZ ([31:24]==8'b10110100).
REQ-013 SHALL deassert stall whenever flush==1 (flush priority).
REQ-014 Normal cycle (no stall, no flush): instr_reg<=instr_if; instr_reg_ex<=instr_reg, RegWrite_exe<=RegWrite_dec; MEM<=EX; WB<=MEM (instr and RegWrite).
REQ-015 Stall cycle: instr_reg holds; instr_reg_ex<=NOP, RegWrite_exe<=0; MEM and WB advance normally.
REQ-016 Flush cycle: instr_reg<=NOP; instr_reg_ex<=NOP, RegWrite_exe<=0; MEM and WB advance normally.
REQ-017 Stall SHALL last exactly one cycle per load-use pair, since the bubble in EX is not LDUR.
REQ-018 Latency: an instruction reaches instr_reg_ex 1 cycle after instr_reg, instr_reg_mem 2 cycles, instr_reg_wb 3 cycles, plus 1 per stall cycle before EX entry.
REQ-019 stall_count SHALL increment by 1 each cycle stall==1 and saturate at 16'hFFFF.
REQ-020 A load with rd==31 SHALL never stall (X31 = XZR).

Reset
REQ-021 While reset==1 at a rising edge: all four instruction registers <= NOP, all RegWrite outputs <= 0, stall_count <= 0.
REQ-022 Reset SHALL take priority over flush and stall; stall output SHALL read 0 the cycle after reset.
REQ-023 Reset asserted mid-stall SHALL discard the held instr_reg (becomes NOP).

Structure
REQ-024 Shared package pipe_pkg SHALL hold NOP, LDUR/STUR (11-bit) and CBZ (8-bit) opcode constants and the 5-bit XZR index.
REQ-025 One sub-module pipe_reg (33-bit register: instr + RegWrite, with enable and synchronous load-NOP) SHALL be instantiated per stage.
REQ-026 Load-use detection SHALL be a single always_comb block; no latches.

Verification
REQ-027 Reset then instr_if=ADD X1,X2,X3 for 4 cycles -> appears at instr_reg_wb on cycle 4, RegWrite_wb=1 with RegWrite_dec=1.
REQ-028 LDUR X5,[X6] then ADD X7,X5,X8 -> stall=1 one cycle, instr_reg_ex=NOP, ADD enters EX next cycle, stall_count=1.
REQ-029 LDUR X31,[X6] then ADD X7,X31,X8 -> stall never asserted.
REQ-030 LDUR X4 then STUR X4,[X9] (Rt match) -> one stall; LDUR X4 then CBZ X4 -> one stall.
REQ-031 Load-use condition with flush=1 same cycle -> stall=0, instr_reg and instr_reg_ex become NOP, stall_count unchanged.
REQ-032 Force 65537 stall cycles -> stall_count holds 16'hFFFF; reset -> 0.
